// File: rtl/mem_pkg.sv
// Shared types for the memory/writeback stage: FSM states, access sizes,
// the in_op field layout and small lane helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    WB       = 2'd3
  } wb_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  // in_op = {is_store, is_unsigned, size[1:0]}
  typedef struct packed {
    logic  is_store;
    logic  is_unsigned;
    size_e size;
  } op_t;

  function automatic logic [7:0] byte_mask(size_e s);
    case (s)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e s, logic [2:0] off);
    case (s)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [63:0] replicate_lanes(logic [63:0] d, size_e s);
    case (s)
      SIZE_B:  return {8{d[7:0]}};
      SIZE_H:  return {4{d[15:0]}};
      SIZE_W:  return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane out of a 64-bit read word and zero/sign-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  logic [63:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = lane;
    case (size)
      SIZE_B:  data = is_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      SIZE_H:  data = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      SIZE_W:  data = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: issues one aligned load/store per accepted result,
// or passes register results straight through to the register file.
module mem_writeback
  import mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [4:0]        in_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [7:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_err
);

  wb_state_e         state_reg, state_next;
  op_t               op_reg;
  op_t               in_op_s;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [4:0]        rd_reg;
  logic              misalign_reg, misalign_next;
  logic              capture, in_misaligned, load_done;
  logic [DATA_W-1:0] load_data;

  assign in_op_s       = op_t'(in_op);
  assign capture       = in_valid && (state_reg == IDLE);
  assign in_misaligned = is_misaligned(in_op_s.size, in_addr[2:0]);
  assign misalign_next = capture && in_mem && in_misaligned;

  // A load completes on rvalid in WAIT_RSP, or in REQ when it arrives with the grant.
  assign load_done = !op_reg.is_store && mem_rvalid &&
                     ((state_reg == WAIT_RSP) || (state_reg == REQ && mem_gnt));

  load_align u_load_align (
    .rdata       (mem_rdata),
    .offset      (addr_reg[2:0]),
    .size        (op_reg.size),
    .is_unsigned (op_reg.is_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      rd_reg       <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      misalign_reg <= misalign_next;
      if (capture) begin
        op_reg   <= in_op_s;
        addr_reg <= in_addr;
        rd_reg   <= in_rd;
      end
      // data_reg holds store data / pass-through result, then the load result.
      if (load_done) data_reg <= load_data;
      else if (capture) data_reg <= in_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!in_mem) state_next = WB;
          else if (!in_misaligned) state_next = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (op_reg.is_store) state_next = IDLE;
          else if (mem_rvalid) state_next = WB;
          else state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: if (mem_rvalid) state_next = WB;
      WB:       state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_reg == IDLE);
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_be       = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    wb_en        = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    misalign_err = misalign_reg;
    if (state_reg == REQ) begin
      mem_req   = 1'b1;
      mem_we    = op_reg.is_store;
      mem_be    = byte_mask(op_reg.size) << addr_reg[2:0];
      mem_addr  = {addr_reg[ADDR_W-1:3], 3'b000};
      mem_wdata = replicate_lanes(data_reg, op_reg.size);
    end
    if (state_reg == WB) begin
      wb_en   = (rd_reg != 5'd0);
      wb_rd   = rd_reg;
      wb_data = data_reg;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Directed and randomized checks of mem_writeback against a byte-level model.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_mem = 1'b0;
  logic [3:0]  in_op = '0;
  logic [63:0] in_data = '0, in_addr = '0;
  logic [4:0]  in_rd = '0;
  logic        mem_req, mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] last_wb;

  mem_writeback #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem(in_mem), .in_op(in_op),
    .in_data(in_data), .in_addr(in_addr), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte arithmetic straight from the access rules.
  function automatic int nbytes(logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit model_misaligned(logic [1:0] size, logic [63:0] addr);
    return (int'(addr[2:0]) % nbytes(size)) != 0;
  endfunction

  function automatic logic [7:0] model_be(logic [1:0] size, logic [63:0] addr);
    int m;
    m = ((1 << nbytes(size)) - 1) << int'(addr[2:0]);
    return m[7:0];
  endfunction

  function automatic logic [63:0] model_wdata(logic [1:0] size, logic [63:0] data);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = data[8*(i % nbytes(size)) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(logic [1:0] size, logic uns, logic [63:0] addr,
                                             logic [63:0] rdata);
    logic [63:0] v, mask;
    int bits;
    bits = 8 * nbytes(size);
    v = rdata >> (8 * int'(addr[2:0]));
    if (bits < 64) begin
      mask = (64'd1 << bits) - 64'd1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic run_txn(input bit mem, input logic [3:0] op, input logic [63:0] data,
                         input logic [63:0] addr, input logic [4:0] rd, input int gd,
                         input int rvd, input logic [63:0] rdata);
    int n_wait;
    logic [1:0] size;
    logic store, uns;
    size  = op[1:0];
    store = op[3];
    uns   = op[2];
    n_wait = 0;
    while (!in_ready && n_wait < 20) begin tick(); n_wait++; end
    chk("ready_before", in_ready, 1'b1);
    in_valid = 1'b1; in_mem = mem; in_op = op; in_data = data; in_addr = addr; in_rd = rd;
    tick();
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    in_addr = {$urandom, $urandom};
    in_rd = 5'($urandom);
    in_op = 4'($urandom);
    if (!mem) begin
      chk("pt_wb_en", wb_en, rd != 5'd0);
      chk("pt_wb_rd", wb_rd, rd);
      chk("pt_wb_data", wb_data, data);
      chk("pt_ready_in_wb", in_ready, 1'b0);
      chk("pt_no_req", mem_req, 1'b0);
      last_wb = wb_data;
      tick();
      chk("pt_wb_once", wb_en, 1'b0);
      chk("pt_idle", in_ready, 1'b1);
    end else if (model_misaligned(size, addr)) begin
      chk("mis_err", misalign_err, 1'b1);
      chk("mis_no_req", mem_req, 1'b0);
      chk("mis_no_wb", wb_en, 1'b0);
      tick();
      chk("mis_err_once", misalign_err, 1'b0);
      chk("mis_no_req2", mem_req, 1'b0);
      chk("mis_no_wb2", wb_en, 1'b0);
    end else begin
      for (int k = 0; k <= gd; k++) begin
        chk("req", mem_req, 1'b1);
        chk("req_addr", mem_addr, {addr[63:3], 3'b000});
        chk("req_we", mem_we, store);
        chk("req_be", mem_be, model_be(size, addr));
        if (store) chk("req_wdata", mem_wdata, model_wdata(size, data));
        if (k == gd) begin
          mem_gnt = 1'b1;
          if (!store && rvd == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
        end
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
      if (store) begin
        chk("st_done_req", mem_req, 1'b0);
        chk("st_no_wb", wb_en, 1'b0);
        chk("st_idle", in_ready, 1'b1);
      end else begin
        for (int k = 0; k < rvd; k++) begin
          chk("wait_no_req", mem_req, 1'b0);
          chk("wait_no_wb", wb_en, 1'b0);
          mem_gnt = 1'($urandom);
          if (k == rvd - 1) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
          tick();
          mem_gnt = 1'b0;
          mem_rvalid = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
        chk("ld_wb_en", wb_en, rd != 5'd0);
        chk("ld_wb_rd", wb_rd, rd);
        chk("ld_wb_data", wb_data, model_load(size, uns, addr, rdata));
        chk("ld_ready_in_wb", in_ready, 1'b0);
        last_wb = wb_data;
        tick();
        chk("ld_wb_once", wb_en, 1'b0);
        chk("ld_idle", in_ready, 1'b1);
      end
    end
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [63:0] r_addr;
    bit          r_mem;
    logic [4:0]  r_rd;

    #3;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_be", mem_be, 8'h00);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_wb_data", wb_data, 64'h0);
    chk("rst_err", misalign_err, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // rvalid/gnt while idle must be ignored
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("idle_ignore_wb", wb_en, 1'b0);
    chk("idle_ignore_req", mem_req, 1'b0);

    run_txn(1'b0, 4'b0000, 64'h1234, 64'h0, 5'd5, 0, 0, 64'h0);
    chk("pt_0x1234", last_wb, 64'h1234);

    run_txn(1'b1, 4'b0000, 64'h55, 64'h1003, 5'd7, 0, 2, 64'h0000_0000_8000_0000);
    chk("lb_sext", last_wb, 64'hFFFF_FFFF_FFFF_FF80);

    run_txn(1'b1, 4'b1001, 64'hABCD, 64'h2006, 5'd3, 3, 0, 64'h0);

    run_txn(1'b1, 4'b0010, 64'h0, 64'h1002, 5'd9, 0, 0, 64'h0);

    run_txn(1'b1, 4'b0011, 64'h0, 64'h4008, 5'd0, 0, 0, 64'h0123_4567_89AB_CDEF);

    run_txn(1'b1, 4'b0111, 64'h0, 64'h4010, 5'd4, 1, 1, 64'hF123_4567_89AB_CDEF);
    chk("ld_unsigned_d", last_wb, 64'hF123_4567_89AB_CDEF);

    // Reset while a load waits for its response
    in_valid = 1'b1; in_mem = 1'b1; in_op = 4'b0011; in_addr = 64'h3000; in_rd = 5'd6;
    tick();
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("wait_state_ready", in_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_wb_en", wb_en, 1'b0);
    chk("arst_wb_data", wb_data, 64'h0);
    chk("arst_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    chk("arst_drop_rvalid", wb_en, 1'b0);
    tick();
    chk("arst_drop_rvalid2", wb_en, 1'b0);
    chk("arst_ready_after", in_ready, 1'b1);

    // Reset while a request is outstanding drops mem_req immediately
    in_valid = 1'b1; in_mem = 1'b1; in_op = 4'b1010; in_addr = 64'h5004; in_data = 64'h77;
    tick();
    in_valid = 1'b0;
    chk("req_before_rst", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req_mid", mem_req, 1'b0);
    chk("arst_addr_mid", mem_addr, 64'h0);
    chk("arst_wdata_mid", mem_wdata, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("after_rst_idle", mem_req, 1'b0);

    for (int t = 0; t < 60; t++) begin
      r_mem = ($urandom_range(0, 3) != 0);
      r_op = 4'($urandom);
      r_addr = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) r_addr[2:0] = r_addr[2:0] & ~3'(nbytes(r_op[1:0]) - 1);
      r_rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      run_txn(r_mem, r_op, {$urandom, $urandom}, r_addr, r_rd, $urandom_range(0, 3),
              $urandom_range(0, 3), {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
